l1_byte_requester: RTL and testbench

- CPU-side initiator for the L1 byte interface. Accepts one load/store from the execute stage: byte, half or word, aligned.
- Splits it into sequential single-byte L1 transactions on Valid/Wen/Addr/ByteData, waiting for Ready/ByteOut on each.
- Assembles little-endian load data with sign or zero extension and returns one response per request.
- Sits between the LSU stage and the L1 data cache.

---
 rtl/l1_byte_requester.sv | 209 ++++++++++++++++++++
 tb/tb_l1_byte_requester.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_byte_requester.sv
// CPU-side initiator for the L1 byte interface: splits an aligned byte/half/word
// load or store into sequential single-byte L1 transactions and returns one response.
module l1_byte_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        l1_valid_o,
    output logic        l1_wen_o,
    output logic [31:0] l1_addr_o,
    output logic [7:0]  l1_bytedata_o,
    input  logic        l1_ready_i,
    input  logic [7:0]  l1_byteout_i
);

    // A zero timeout yields a zero-width counter; keep at least one bit.
    localparam int unsigned WdW    = (CNT_W < 1) ? 1 : CNT_W;
    localparam int unsigned WdLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e         r_state;
    logic           r_wen;
    logic [1:0]     r_size;
    logic           r_unsigned;
    logic [31:0]    r_wdata;
    logic [1:0]     r_k;
    logic [1:0]     r_last_k;
    logic [WdW-1:0] r_wd;
    logic [31:0]    r_asm;

    logic           r_req_ready;
    logic           r_resp_valid;
    logic [31:0]    r_resp_rdata;
    logic           r_resp_err;
    logic           r_l1_valid;
    logic           r_l1_wen;
    logic [31:0]    r_l1_addr;
    logic [7:0]     r_l1_bytedata;

    logic           w_req_err;
    logic [1:0]     w_last_k;
    logic [31:0]    w_asm_new;
    logic [31:0]    w_resp_data;
    logic [7:0]     w_next_byte;
    logic           w_wd_expired;

    always_comb begin
        w_req_err = (req_size_i == 2'd3) ||
                    ((req_size_i == 2'd1) && req_addr_i[0]) ||
                    ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
        case (req_size_i)
            2'd0:    w_last_k = 2'd0;
            2'd1:    w_last_k = 2'd1;
            default: w_last_k = 2'd3;
        endcase
    end

    // Assembly including the byte returned this cycle, so the final byte
    // can feed the response without an extra cycle.
    always_comb begin
        w_asm_new = r_asm;
        w_asm_new[{r_k, 3'b000} +: 8] = l1_byteout_i;
    end

    always_comb begin
        w_resp_data = 32'h0;
        if (!r_wen) begin
            case (r_size)
                2'd0:    w_resp_data = r_unsigned ? {24'h0, w_asm_new[7:0]}
                                                  : {{24{w_asm_new[7]}}, w_asm_new[7:0]};
                2'd1:    w_resp_data = r_unsigned ? {16'h0, w_asm_new[15:0]}
                                                  : {{16{w_asm_new[15]}}, w_asm_new[15:0]};
                default: w_resp_data = w_asm_new;
            endcase
        end
    end

    always_comb begin
        case (r_k)
            2'd0:    w_next_byte = r_wdata[15:8];
            2'd1:    w_next_byte = r_wdata[23:16];
            default: w_next_byte = r_wdata[31:24];
        endcase
    end

    assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (r_wd == WdW'(WdLast));

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_wen         <= 1'b0;
            r_size        <= 2'd0;
            r_unsigned    <= 1'b0;
            r_wdata       <= 32'h0;
            r_k           <= 2'd0;
            r_last_k      <= 2'd0;
            r_wd          <= '0;
            r_asm         <= 32'h0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= 32'h0;
            r_resp_err    <= 1'b0;
            r_l1_valid    <= 1'b0;
            r_l1_wen      <= 1'b0;
            r_l1_addr     <= 32'h0;
            r_l1_bytedata <= 8'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_req_ready <= 1'b0;
                        r_wen       <= req_wen_i;
                        r_size      <= req_size_i;
                        r_unsigned  <= req_unsigned_i;
                        r_wdata     <= req_wdata_i;
                        r_last_k    <= w_last_k;
                        r_k         <= 2'd0;
                        r_wd        <= '0;
                        r_asm       <= 32'h0;
                        if (w_req_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_state       <= StIssue;
                            r_l1_valid    <= 1'b1;
                            r_l1_wen      <= req_wen_i;
                            r_l1_addr     <= req_addr_i;
                            r_l1_bytedata <= req_wdata_i[7:0];
                        end
                    end
                end
                StIssue: begin
                    // l1_ready_i takes priority over a simultaneous watchdog expiry.
                    if (l1_ready_i) begin
                        r_wd <= '0;
                        if (!r_wen) begin
                            r_asm <= w_asm_new;
                        end
                        if (r_k == r_last_k) begin
                            r_state       <= StResp;
                            r_l1_valid    <= 1'b0;
                            r_l1_wen      <= 1'b0;
                            r_l1_addr     <= 32'h0;
                            r_l1_bytedata <= 8'h0;
                            r_resp_valid  <= 1'b1;
                            r_resp_err    <= 1'b0;
                            r_resp_rdata  <= w_resp_data;
                        end else begin
                            r_k           <= r_k + 2'd1;
                            r_l1_addr     <= r_l1_addr + 32'd1;
                            r_l1_bytedata <= w_next_byte;
                        end
                    end else if (w_wd_expired) begin
                        r_state       <= StResp;
                        r_l1_valid    <= 1'b0;
                        r_l1_wen      <= 1'b0;
                        r_l1_addr     <= 32'h0;
                        r_l1_bytedata <= 8'h0;
                        r_asm         <= 32'h0;
                        r_resp_valid  <= 1'b1;
                        r_resp_err    <= 1'b1;
                        r_resp_rdata  <= 32'h0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                StResp: begin
                    r_state      <= StIdle;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o   = r_req_ready;
    assign resp_valid_o  = r_resp_valid;
    assign resp_rdata_o  = r_resp_rdata;
    assign resp_err_o    = r_resp_err;
    assign l1_valid_o    = r_l1_valid;
    assign l1_wen_o      = r_l1_wen;
    assign l1_addr_o     = r_l1_addr;
    assign l1_bytedata_o = r_l1_bytedata;

endmodule

// File: tb/tb_l1_byte_requester.sv
// Directed bench for l1_byte_requester: loads, stores, alignment errors,
// watchdog timeout and mid-transaction reset.
module tb_l1_byte_requester;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wen_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        l1_valid_o;
    logic        l1_wen_o;
    logic [31:0] l1_addr_o;
    logic [7:0]  l1_bytedata_o;
    logic        l1_ready_i;
    logic [7:0]  l1_byteout_i;

    int n_checks = 0;
    int n_fail   = 0;

    l1_byte_requester #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_wen_i     (req_wen_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_err_o    (resp_err_o),
        .l1_valid_o    (l1_valid_o),
        .l1_wen_o      (l1_wen_o),
        .l1_addr_o     (l1_addr_o),
        .l1_bytedata_o (l1_bytedata_o),
        .l1_ready_i    (l1_ready_i),
        .l1_byteout_i  (l1_byteout_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready"}, req_ready_o, 1'b1);
        chk({tag, " rvalid"}, resp_valid_o, 1'b0);
        chk({tag, " l1valid"}, l1_valid_o, 1'b0);
    endtask

    // Present one request, act as L1 with latency lat returning rsp byte k for
    // byte k, and check each L1 beat plus the response timing and value.
    task automatic run_access(input string tag, input logic wen, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rsp, input logic [31:0] exp_rdata,
                              input logic exp_err);
        int        n;
        logic [31:0] sh;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        chk({tag, " accept ready"}, req_ready_o, 1'b1);
        req_valid_i    = 1'b1;
        req_wen_i      = wen;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        tick();
        req_valid_i = 1'b0;
        if (!exp_err) begin
            for (int k = 0; k < n; k++) begin
                for (int c = 1; c <= lat; c++) begin
                    sh = wdata >> (8 * k);
                    chk($sformatf("%s b%0d c%0d l1valid", tag, k, c), l1_valid_o, 1'b1);
                    chk($sformatf("%s b%0d c%0d wen", tag, k, c), l1_wen_o, wen);
                    chk($sformatf("%s b%0d c%0d addr", tag, k, c), l1_addr_o, addr + k);
                    chk($sformatf("%s b%0d c%0d bdata", tag, k, c), l1_bytedata_o, sh[7:0]);
                    chk($sformatf("%s b%0d c%0d rvalid", tag, k, c), resp_valid_o, 1'b0);
                    if (c == lat) begin
                        sh           = rsp >> (8 * k);
                        l1_ready_i   = 1'b1;
                        l1_byteout_i = sh[7:0];
                    end
                    tick();
                    l1_ready_i   = 1'b0;
                    l1_byteout_i = 8'h00;
                end
            end
        end else begin
            chk({tag, " no l1valid"}, l1_valid_o, 1'b0);
        end
        chk({tag, " resp valid"}, resp_valid_o, 1'b1);
        chk({tag, " resp err"}, resp_err_o, exp_err);
        chk({tag, " resp rdata"}, resp_rdata_o, exp_rdata);
        chk({tag, " resp l1valid"}, l1_valid_o, 1'b0);
        chk({tag, " resp busy"}, req_ready_o, 1'b0);
        tick();
        chk_idle({tag, " after"});
    endtask

    initial begin
        rst            = 1'b1;
        req_valid_i    = 1'b0;
        req_wen_i      = 1'b0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
        l1_ready_i     = 1'b0;
        l1_byteout_i   = 8'h00;
        repeat (2) @(posedge clk_i);
        #1;
        chk_idle("reset");
        chk("reset rdata", resp_rdata_o, 32'h0);
        chk("reset err", resp_err_o, 1'b0);
        chk("reset addr", l1_addr_o, 32'h0);
        chk("reset bdata", l1_bytedata_o, 8'h00);
        chk("reset wen", l1_wen_o, 1'b0);
        rst = 1'b0;
        tick();

        run_access("LW100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'h44332211,
                   32'h44332211, 1'b0);
        run_access("LB205", 1'b0, 2'd0, 1'b0, 32'h205, 32'h0, 1, 32'h00000080,
                   32'hFFFFFF80, 1'b0);
        run_access("LBU205", 1'b0, 2'd0, 1'b1, 32'h205, 32'h0, 2, 32'h00000080,
                   32'h00000080, 1'b0);
        run_access("LH206", 1'b0, 2'd1, 1'b0, 32'h206, 32'h0, 1, 32'h0000F234,
                   32'hFFFFF234, 1'b0);
        run_access("LHU206", 1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 1, 32'h0000F234,
                   32'h0000F234, 1'b0);
        run_access("SH10", 1'b1, 2'd1, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h00005555,
                   32'h0, 1'b0);
        run_access("LWwrap", 1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 1, 32'h01020304,
                   32'h01020304, 1'b0);
        run_access("ELW102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1, 32'h0, 32'h0, 1'b1);
        run_access("ESH11", 1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, 1, 32'h0, 32'h0, 1'b1);
        run_access("ESZ3", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1, 32'h0, 32'h0, 1'b1);

        // Watchdog: L1 never answers; valid holds exactly 8 cycles.
        req_valid_i = 1'b1;
        req_wen_i   = 1'b0;
        req_size_i  = 2'd0;
        req_addr_i  = 32'h300;
        tick();
        req_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("wd c%0d l1valid", c), l1_valid_o, 1'b1);
            chk($sformatf("wd c%0d rvalid", c), resp_valid_o, 1'b0);
            tick();
        end
        chk("wd l1valid drop", l1_valid_o, 1'b0);
        chk("wd resp valid", resp_valid_o, 1'b1);
        chk("wd resp err", resp_err_o, 1'b1);
        chk("wd resp rdata", resp_rdata_o, 32'h0);
        l1_ready_i   = 1'b1;
        l1_byteout_i = 8'hAA;
        tick();
        l1_ready_i   = 1'b0;
        l1_byteout_i = 8'h00;
        chk_idle("wd late ready");
        run_access("LBpostwd", 1'b0, 2'd0, 1'b1, 32'h301, 32'h0, 2, 32'h0000007F,
                   32'h0000007F, 1'b0);

        // Reset in the middle of a word load after two bytes.
        req_valid_i = 1'b1;
        req_size_i  = 2'd2;
        req_addr_i  = 32'h400;
        tick();
        req_valid_i  = 1'b0;
        l1_ready_i   = 1'b1;
        l1_byteout_i = 8'h99;
        repeat (2) tick();
        l1_ready_i = 1'b0;
        chk("mid addr", l1_addr_o, 32'h402);
        rst = 1'b1;
        #1;
        chk_idle("mid reset");
        chk("mid reset addr", l1_addr_o, 32'h0);
        chk("mid reset wen", l1_wen_o, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("post reset c%0d rvalid", c), resp_valid_o, 1'b0);
            tick();
        end
        run_access("LWpostrst", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 2, 32'h8877CCDD,
                   32'h8877CCDD, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
